// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, registered borrow, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    // Only WIDTH-1 processed bits are kept; the final bit goes straight into diff.
    logic [WIDTH-2:0]   sd_q, sd_d;
    logic               bq_q, bq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;

    logic               bit_d;
    logic               borrow_nxt;
    logic               last_bit;
    logic [WIDTH-1:0]   sd_ext;

    always_comb begin
        bit_d      = sa_q[0] ^ sb_q[0] ^ bq_q;
        borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bq_q);
        last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
        sd_ext     = {bit_d, sd_q};

        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        bq_d     = bq_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bq_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                sd_d = sd_ext[WIDTH-1:1];
                bq_d = borrow_nxt;
                if (last_bit) begin
                    // On the last cycle sa_q[0]/sb_q[0] are the operand sign bits.
                    diff_d   = sd_ext;
                    borrow_d = borrow_nxt;
                    ovf_d    = (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ bit_d);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            bq_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            bq_q     <= bq_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 vector table, back-to-back, reset cases,
// plus an exhaustive WIDTH=2 instance. Checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int W2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start, busy, done, borrow, ovf;
    logic [W-1:0]  a, b, diff;
    logic          start2, busy2, done2, borrow2, ovf2;
    logic [W2-1:0] a2, b2, diff2;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(W2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf  = 1'b0;
    assign ovf2 = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard entries are {ovf, borrow, diff}.
    logic [W+1:0]  exp_q[$];
    logic [W2+1:0] exp2_q[$];
    logic [W+1:0]  mon_e;
    logic [W2+1:0] mon_e2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model8(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x - y;
        return {(x[W-1] ^ y[W-1]) & (x[W-1] ^ d[W-1]), (x < y), d};
    endfunction

    function automatic logic [W2+1:0] model2(input logic [W2-1:0] x, input logic [W2-1:0] y);
        logic [W2-1:0] d;
        d = x - y;
        return {(x[W2-1] ^ y[W2-1]) & (x[W2-1] ^ d[W2-1]), (x < y), d};
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("diff", diff, mon_e[W-1:0]);
                check("borrow", borrow, mon_e[W]);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", ovf, mon_e[W+1]);
`endif
            end
        end
        if (done2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_done2", done2, 0);
            end else begin
                mon_e2 = exp2_q.pop_front();
                check("diff2", diff2, mon_e2[W2-1:0]);
                check("borrow2", borrow2, mon_e2[W2]);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf2", ovf2, mon_e2[W2+1]);
`endif
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W+1:0] exp, input bit glitch);
        int cyc;
        int busy_cnt;
        bit got;
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        cyc = 0; busy_cnt = 0; got = 0;
        while (!got && cyc < W + 5) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
            end else begin
                if (busy) busy_cnt++;
                start = glitch && (cyc == 3);
                if (start) begin
                    a = W'($urandom); b = W'($urandom);
                end
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("latency", cyc, W + 1);
        check("busy_cycles", busy_cnt, W);
        check("busy_in_done", busy, 0);
    endtask

    task automatic back_to_back(input int n);
        int cyc;
        bit got;
        logic [W-1:0] x, y;
        @(negedge clk);
        x = W'($urandom); y = W'($urandom);
        start = 1'b1; a = x; b = y;
        exp_q.push_back(model8(x, y));
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            a = W'($urandom); b = W'($urandom);
            cyc = 0; got = 0;
            while (!got && cyc < W + 5) begin
                @(negedge clk);
                cyc++;
                if (done) got = 1;
            end
            check("b2b_period", cyc, W + 1);
            if (k < n - 1) begin
                x = W'($urandom); y = W'($urandom);
                a = x; b = y;
                exp_q.push_back(model8(x, y));
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic do_op2(input logic [W2-1:0] x, input logic [W2-1:0] y);
        int cyc;
        bit got;
        @(negedge clk);
        start2 = 1'b1; a2 = x; b2 = y;
        exp2_q.push_back(model2(x, y));
        @(posedge clk);
        #1;
        start2 = 1'b0; a2 = ~x; b2 = ~y;
        cyc = 0; got = 0;
        while (!got && cyc < W2 + 5) begin
            @(negedge clk);
            cyc++;
            if (done2) got = 1;
        end
        check("latency2", cyc, W2 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_busy2", busy2, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b,
                  {vecs[i].ovf, vecs[i].borrow, vecs[i].diff}, (i % 2) == 1);

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            do_op(x, y, model8(x, y), (i % 3) == 0);
        end

        back_to_back(5);

        // Abort mid-run: previous result is nonzero, so clearing is observable.
        do_op(8'h00, 8'h01, model8(8'h00, 8'h01), 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", ovf, 0);
`endif
        rst = 1'b0;
        done_cnt = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 0);
        do_op(8'h10, 8'h01, {1'b0, 1'b0, 8'h0F}, 1'b0);

        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_dropped", busy, 0);
        check("rst_start_diff", diff, 0);

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                do_op2(W2'(x), W2'(y));

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size() + exp2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, parametrised N-bit subtractor. Computes `a - b` one bit per clock, LSB first, with a single full-subtractor cell and a registered borrow. The result is held stable until the next operation, and a start/busy/done handshake is provided. It is the multi-bit, sequential successor to the combinational half/full subtractor cells, for area-constrained datapaths where latency is acceptable.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Legal range is 2..64.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a subtraction. Sampled only when `busy`=0.
- `a`  input  WIDTH  minuend, captured on an accepted start.
- `b`  input  WIDTH  subtrahend, captured on an accepted start.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when `diff`/`borrow` update.
- `diff`  output  WIDTH  result `(a - b) mod 2^WIDTH`.
- `borrow`  output  1  final borrow-out; 1 iff `a < b` (unsigned).
- `ovf`  output  1  signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:** `busy`=0, `done`=0.
  - On `start`=1: load shift registers `sa<=a` and `sb<=b`.
  - Clear the borrow flop `bq<=0` and the bit counter `cnt<=0`.
  - Go to RUN.
- **RUN:** `busy`=1. Each cycle:
  - Bit difference: `d = sa[0]^sb[0]^bq`.
  - Next borrow: `bq <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bq)`.
  - Shift `sa` and `sb` right by 1.
  - Shift `d` into the MSB of the partial-result register `sd`.
  - Increment `cnt`.
  - When `cnt` reaches WIDTH-1 (last bit processed this cycle), go to DONE.
- **DONE:** `busy`=0, `done`=1 for exactly this cycle.
  - `diff`, `borrow` (and `ovf`) were loaded from `sd`/`bq` on the transition edge.
  - Next state is IDLE. If `start`=1 in DONE, the start is accepted exactly as in IDLE and the next state is RUN.
- **Outputs:** `diff`, `borrow` and `ovf` are separate result registers. They change only on RUN→DONE and are held indefinitely otherwise. Partial results are never visible.
- **Start while busy:** `start` in RUN is ignored. It is neither queued nor allowed to disturb the operation. `a`/`b` may change freely after capture.
- **Counter:** `cnt` width is `$clog2(WIDTH)`. It never wraps past WIDTH-1.

## Timing
- **Latency:** start sampled at edge 0; RUN occupies WIDTH cycles; `done`=1 and the new `diff` are visible in the cycle after edge WIDTH. Start to done is WIDTH+1 cycles.
- **Throughput:** one operation per WIDTH+1 cycles, achieved by asserting start during DONE.
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0. Internal `sa`, `sb`, `sd`, `bq` and `cnt` are all 0.
- **Reset mid-operation:** `rst` has priority over all other inputs. The operation is aborted, no `done` pulse is produced, and outputs return to 0 on the next edge.
- **Reset and start together:** `rst`=1 together with `start`=1 results in IDLE, and the start is dropped.

## Configuration
- **`SERIAL_SUB_OVF_EN` defined:**
  - Port `ovf` exists.
  - On the final RUN cycle, `ovf <= (a_msb ^ b_msb) & (a_msb ^ d)`, using the MSB bits being processed in that cycle. This is two's-complement overflow.
  - `ovf` is held and reset the same way as `diff`.
- **`SERIAL_SUB_OVF_EN` undefined:** no `ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
1. a=0x05, b=0x03, start pulse → `busy` high for 8 cycles; `done` pulse at cycle 9; `diff`=0x02, `borrow`=0.
2. a=0x03, b=0x05 → `diff`=0xFE, `borrow`=1. Then a=0x00, b=0x00 → `diff`=0x00, `borrow`=0. Then a=0x00, b=0xFF → `diff`=0x01, `borrow`=1.
3. `start` held high continuously with new operands each DONE cycle → back-to-back results every 9 cycles, each correct. `start` pulses during RUN, with different a/b, do not alter the current result.
4. `rst` asserted at RUN cycle 4 → next cycle `busy`=0, `diff`=0, `borrow`=0; no `done` pulse. A following start with 0x10-0x01 gives 0x0F, `borrow`=0.
5. With `SERIAL_SUB_OVF_EN`:
   - 0x80-0x01 → `diff`=0x7F, `ovf`=1, `borrow`=0.
   - 0x7F-0xFF → `diff`=0x80, `ovf`=1, `borrow`=1.
   - 0x05-0x03 → `ovf`=0.
6. WIDTH=2 build, exhaustive over all 16 a/b pairs → `diff`=(a-b)&3 and `borrow`=(a<b) in every case; latency is 3 cycles.
